pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register with a valid/ready handshake, hold (stall_i) and kill (flush_i).
//  A 2-entry skid buffer (main + skid) keeps in_ready_o registered, so upstream ready never depends combinationally on out_ready_i.

---
 rtl/pipe_stage_reg_if.sv | 22 ++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipe_stage_reg boundary: upstream valid/ready/data in, downstream valid/ready/data out.
// The stage itself connects to the slave modport; the driving environment uses master.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, stall (hold) and flush (kill).
// Optional perf counters (stall/bubble cycles) are built when PIPE_STAGE_PERF_EN is defined.
// Handshake: a beat transfers on a posedge where valid and ready are both high; in_ready_o is a
// flop output (low only when the skid entry is occupied), and out_valid_o is gated by stall_i.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_stage_reg_if.slave  bus,
  input  logic             stall_i,
  input  logic             flush_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
`endif
  output logic [1:0]       state_o
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: WIDTH and CNT_W must be at least 1");
  end

  // Encoding is {main_valid, skid_valid}; (0,1) never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_from_in;
  logic             w_main_from_skid;
  logic             w_skid_from_in;

  assign w_in_fire  = bus.in_valid_i & bus.in_ready_o;
  assign w_out_fire = r_state[1] & bus.out_ready_i & ~stall_i;

  always_comb begin
    w_state_next     = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next   = ST_ONE;
          w_main_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_from_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_next   = ST_TWO;
          w_skid_from_in = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_state_next     = ST_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Flush discards both entries and any payload accepted in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state <= ST_EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_state_next;
      if (w_main_from_in) begin
        r_main <= bus.in_data_i;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= bus.in_data_i;
      end
    end
  end

  assign bus.in_ready_o  = ~r_state[0];
  assign bus.out_valid_o = r_state[1] & ~stall_i;
  assign bus.out_data_o  = r_main;
  assign state_o         = r_state;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_state[1] && (stall_i || !bus.out_ready_i) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (!r_state[1] && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenario tasks plus a random burst, with a queue scoreboard
// checking every delivered beat. Build with PIPE_STAGE_PERF_EN defined to also check the counters.
module tb_pipe_stage_reg;
  localparam int unsigned      W     = 16;
  localparam logic [W-1:0]     RVAL  = 16'hDEAD;
  localparam int unsigned      CW    = 8;
  localparam logic [1:0]       S_EMPTY = 2'b00;
  localparam logic [1:0]       S_ONE   = 2'b10;
  localparam logic [1:0]       S_TWO   = 2'b11;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         flush;
  logic [1:0]   state;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  pipe_stage_reg_if #(.WIDTH(W)) bus ();

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RVAL), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .stall_i     (stall),
    .flush_i     (flush),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt_o (stall_cnt),
    .bubble_cnt_o(bubble_cnt),
`endif
    .state_o     (state)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    flush           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
  end

  // Driver: inputs change on the falling edge and settle before the next rising edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic stl, input logic fl);
    @(negedge clk);
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = ordy;
    stall           = stl;
    flush           = fl;
    #1;
  endtask

  // Scoreboard monitor: samples what the coming rising edge will see.
  always begin
    logic [W-1:0] exp_d;
    logic         exp_rdy;
    logic         exp_vld;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
    end else begin
      exp_rdy = (exp_q.size() < 2);
      exp_vld = (exp_q.size() > 0) && !stall;
      checks++;
      if (bus.in_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL sb_in_ready: got %0b want %0b at %0t", bus.in_ready_o, exp_rdy, $time);
      end
      checks++;
      if (bus.out_valid_o !== exp_vld) begin
        errors++;
        $display("FAIL sb_out_valid: got %0b want %0b at %0t", bus.out_valid_o, exp_vld, $time);
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h want no beat at %0t", bus.out_data_o, $time);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.out_data_o !== exp_d) begin
            errors++;
            $display("FAIL sb_data: got %h want %h at %0t", bus.out_data_o, exp_d, $time);
          end
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (bus.in_valid_i === 1'b1 && bus.in_ready_o === 1'b1) begin
        exp_q.push_back(bus.in_data_i);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || state !== S_EMPTY) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%0b r=%0b s=%b want v=0 r=1 s=00",
               bus.out_valid_o, bus.in_ready_o, state);
    end
    checks++;
    if (bus.out_data_o !== RVAL) begin
      errors++;
      $display("FAIL reset_data: got %h want %h", bus.out_data_o, RVAL);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    end
`endif
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(16'h10 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready: got %0b want 1 beat %0d", bus.in_ready_o, i);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== W'(16'h10 + i - 1)) begin
          errors++;
          $display("FAIL stream_latency: got v=%0b d=%h want v=1 d=%h",
                   bus.out_valid_o, bus.out_data_o, W'(16'h10 + i - 1));
        end
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 16'h001F) begin
      errors++;
      $display("FAIL stream_last: got v=%0b d=%h want v=1 d=001f", bus.out_valid_o, bus.out_data_o);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 16'h001F) begin
      errors++;
      $display("FAIL stream_hold: got v=%0b d=%h want v=0 d=001f", bus.out_valid_o, bus.out_data_o);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    // In TWO the offered beat must be refused.
    drive(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== S_TWO || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got s=%b r=%0b want s=11 r=0", state, bus.in_ready_o);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_data_o !== 16'h000A || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got d=%h r=%0b want d=000a r=0", bus.out_data_o, bus.in_ready_o);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 16'h000B || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got v=%0b d=%h r=%0b want v=1 d=000b r=1",
               bus.out_valid_o, bus.out_data_o, bus.in_ready_o);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== S_EMPTY) begin
      errors++;
      $display("FAIL bp_drain: got s=%b want s=00", state);
    end
  endtask

  task automatic test_stall();
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] base;
`endif
    drive(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    base = stall_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      // First stalled cycle still fills the skid entry.
      drive((i == 0), 16'h0056, 1'b1, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 16'h0055) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b d=%h want v=0 d=0055 cycle %0d",
                 bus.out_valid_o, bus.out_data_o, i);
      end
    end
    checks++;
    if (state !== S_TWO) begin
      errors++;
      $display("FAIL stall_fill: got s=%b want s=11", state);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 16'h0055) begin
      errors++;
      $display("FAIL stall_release: got v=%0b d=%h want v=1 d=0055", bus.out_valid_o, bus.out_data_o);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== CW'(base + 3)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, CW'(base + 3));
    end
`endif
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h0031, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0032, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0033, 1'b0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== S_EMPTY || bus.out_valid_o !== 1'b0 || bus.out_data_o !== RVAL) begin
      errors++;
      $display("FAIL flush_two: got s=%b v=%0b d=%h want s=00 v=0 d=%h",
               state, bus.out_valid_o, bus.out_data_o, RVAL);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Flush in ONE: the outgoing beat completes, the incoming one is dropped.
    drive(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0041, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.out_data_o !== RVAL) begin
      errors++;
      $display("FAIL flush_one: got v=%0b r=%0b d=%h want v=0 r=1 d=%h",
               bus.out_valid_o, bus.in_ready_o, bus.out_data_o, RVAL);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 16'h0071, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0072, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 16'h0073, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 16'h0074, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rst             = 1'b0;
    bus.in_valid_i  = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    #1;
    checks++;
    if (state !== S_EMPTY || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        bus.out_data_o !== RVAL) begin
      errors++;
      $display("FAIL midrst_state: got s=%b v=%0b r=%0b d=%h want s=00 v=0 r=1 d=%h",
               state, bus.out_valid_o, bus.in_ready_o, bus.out_data_o, RVAL);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'(($urandom_range(0, 3) != 0)), W'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), 1'(($urandom_range(0, 4) == 0)),
            1'(($urandom_range(0, 19) == 0)));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0 || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d pending v=%0b want 0 pending v=0",
               exp_q.size(), bus.out_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
